// File: rtl/seq_mac_array.sv
// seq_mac_array: LANES independent signed MAC lanes sharing one valid/ready
// input stream. Each lane accumulates a dot product over a vector delimited
// by in_last. The sum is rounded (half up), arithmetically shifted by SHIFT
// and saturated to DWIDTH. The result sits in a one-entry output buffer.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-low reset
//   in_a/in_b packed signed operands, lane i at [i*DWIDTH +: DWIDTH]
//   in_valid  input beat valid
//   in_last   beat is the final element of the current vector
//   in_ready  block accepts a beat this cycle (combinational)
//   out_data  packed signed results, same packing as the inputs
//   out_sat   per-lane saturation flag for the delivered vector
//   out_valid out_data/out_sat valid
//   out_ready consumer accepts the result
//
// AWIDTH must be at least 2*DWIDTH; SHIFT must be in 0..AWIDTH-1.
`timescale 1ns/1ps
module seq_mac_array #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 24,
    parameter int unsigned LANES  = 4,
    parameter int unsigned SHIFT  = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [LANES*DWIDTH-1:0]   in_a,
    input  logic [LANES*DWIDTH-1:0]   in_b,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [LANES*DWIDTH-1:0]   out_data,
    output logic [LANES-1:0]          out_sat,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int unsigned PW = 2 * DWIDTH;
    localparam int unsigned SW = AWIDTH + 1;

    // Clamp bounds, all expressed at the widened sum width
    localparam logic signed [SW-1:0] ACC_MAX = {2'b00, {(AWIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] ACC_MIN = {2'b11, {(AWIDTH-1){1'b0}}};
    localparam logic signed [SW-1:0] RES_MAX = {{(SW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] RES_MIN = {{(SW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};
    // Half-LSB rounding constant; zero when SHIFT is zero
    localparam logic signed [SW-1:0] RND     = SW'((SW'(1) << SHIFT) >> 1);

    logic                           en_c;
    logic [LANES-1:0][PW-1:0]       prod_q;
    logic                           v1_q;
    logic                           last1_q;
    logic                           mid_q;      // a vector is in progress (inverse of "first")
    logic [LANES-1:0][AWIDTH-1:0]   acc_q;
    logic [LANES-1:0]               sticky_q;

    logic [LANES-1:0][PW-1:0]       prod_c;
    logic [LANES-1:0][AWIDTH-1:0]   acc_nxt_c;
    logic [LANES-1:0]               acc_clip_c;
    logic [LANES-1:0]               res_clip_c;
    logic [LANES*DWIDTH-1:0]        res_c;
    logic signed [SW-1:0]           sum_c [LANES];
    logic signed [SW-1:0]           sat_c [LANES];
    logic signed [SW-1:0]           rnd_c [LANES];

    // Whole pipeline stalls while a result waits on the consumer
    assign en_c     = reset & ~(out_valid & ~out_ready);
    assign in_ready = en_c;

    // Per-lane product, accumulate-with-clamp and round/shift/saturate
    always_comb begin
        prod_c     = '0;
        acc_nxt_c  = '0;
        acc_clip_c = '0;
        res_clip_c = '0;
        res_c      = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_c[i] = '0;
            sat_c[i] = '0;
            rnd_c[i] = '0;
        end
        for (int i = 0; i < LANES; i++) begin
            prod_c[i] = PW'($signed(in_a[i*DWIDTH +: DWIDTH])) *
                        PW'($signed(in_b[i*DWIDTH +: DWIDTH]));

            sum_c[i] = (mid_q ? SW'($signed(acc_q[i])) : '0) + SW'($signed(prod_q[i]));
            sat_c[i] = sum_c[i];
            if (sum_c[i] > ACC_MAX) begin
                sat_c[i]      = ACC_MAX;
                acc_clip_c[i] = 1'b1;
            end else if (sum_c[i] < ACC_MIN) begin
                sat_c[i]      = ACC_MIN;
                acc_clip_c[i] = 1'b1;
            end
            acc_nxt_c[i] = sat_c[i][AWIDTH-1:0];

            // Cannot overflow SW bits: |acc| < 2^(AWIDTH-1) and RND <= 2^(AWIDTH-2)
            rnd_c[i] = (sat_c[i] + RND) >>> SHIFT;
            if (rnd_c[i] > RES_MAX) begin
                res_c[i*DWIDTH +: DWIDTH] = RES_MAX[DWIDTH-1:0];
                res_clip_c[i]             = 1'b1;
            end else if (rnd_c[i] < RES_MIN) begin
                res_c[i*DWIDTH +: DWIDTH] = RES_MIN[DWIDTH-1:0];
                res_clip_c[i]             = 1'b1;
            end else begin
                res_c[i*DWIDTH +: DWIDTH] = rnd_c[i][DWIDTH-1:0];
            end
        end
    end

    // Stage 1 product register, stage 2 accumulators and output buffer
    always_ff @(posedge clk) begin
        if (!reset) begin
            prod_q    <= '0;
            v1_q      <= 1'b0;
            last1_q   <= 1'b0;
            mid_q     <= 1'b0;
            acc_q     <= '0;
            sticky_q  <= '0;
            out_data  <= '0;
            out_sat   <= '0;
            out_valid <= 1'b0;
        end else if (en_c) begin
            prod_q    <= prod_c;
            v1_q      <= in_valid;
            last1_q   <= in_last;
            // en_c implies any pending result is being consumed now
            out_valid <= v1_q & last1_q;
            if (v1_q) begin
                acc_q <= acc_nxt_c;
                mid_q <= ~last1_q;
                if (last1_q) begin
                    out_data <= res_c;
                    out_sat  <= sticky_q | acc_clip_c | res_clip_c;
                    sticky_q <= '0;
                end else begin
                    sticky_q <= sticky_q | acc_clip_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_mac_array.sv
// Scoreboard bench for seq_mac_array: three instances (AWIDTH/SHIFT = 20/0,
// 16/8, 20/4; DWIDTH=8, LANES=2) driven by directed vectors. Expected results
// are queued when stimulus is issued; a monitor pops them on each handshake.
`timescale 1ns/1ps
module tb_seq_mac_array;

    localparam int N = 3;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_a     [N];
    logic [15:0] in_b     [N];
    logic [N-1:0] in_valid;
    logic [N-1:0] in_last;
    logic [N-1:0] in_ready;
    logic [15:0] out_data [N];
    logic [1:0]  out_sat  [N];
    logic [N-1:0] out_valid;
    logic [N-1:0] out_ready;

    exp_t sbq [N][$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    seq_mac_array #(.DWIDTH(8), .AWIDTH(20), .LANES(2), .SHIFT(0)) u0 (
        .clk(clk), .reset(reset), .in_a(in_a[0]), .in_b(in_b[0]),
        .in_valid(in_valid[0]), .in_last(in_last[0]), .in_ready(in_ready[0]),
        .out_data(out_data[0]), .out_sat(out_sat[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]));

    seq_mac_array #(.DWIDTH(8), .AWIDTH(16), .LANES(2), .SHIFT(8)) u1 (
        .clk(clk), .reset(reset), .in_a(in_a[1]), .in_b(in_b[1]),
        .in_valid(in_valid[1]), .in_last(in_last[1]), .in_ready(in_ready[1]),
        .out_data(out_data[1]), .out_sat(out_sat[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]));

    seq_mac_array #(.DWIDTH(8), .AWIDTH(20), .LANES(2), .SHIFT(4)) u2 (
        .clk(clk), .reset(reset), .in_a(in_a[2]), .in_b(in_b[2]),
        .in_valid(in_valid[2]), .in_last(in_last[2]), .in_ready(in_ready[2]),
        .out_data(out_data[2]), .out_sat(out_sat[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input logic [15:0] data, input logic [1:0] sat);
        exp_t e;
        e.data = data;
        e.sat  = sat;
        sbq[k].push_back(e);
    endtask

    task automatic drive(input int k, input int a0, input int b0, input int a1,
                         input int b1, input logic last);
        in_a[k]     = {8'(a1), 8'(a0)};
        in_b[k]     = {8'(b1), 8'(b0)};
        in_valid[k] = 1'b1;
        in_last[k]  = last;
    endtask

    // Present one beat, wait (bounded) for acceptance, then drop valid
    task automatic send(input int k, input int a0, input int b0, input int a1,
                        input int b1, input logic last);
        int n;
        drive(k, a0, b0, a1, b1, last);
        n = 0;
        @(negedge clk);
        while (!in_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[k]) begin
            total++;
            bad++;
            $display("FAIL send_timeout lane_inst=%0d: in_ready stayed 0", k);
        end
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        in_last[k]  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: one comparison set per completed output handshake
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (reset === 1'b1 && out_valid[k] === 1'b1 && out_ready[k] === 1'b1) begin
                if (sbq[k].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out inst=%0d: got data %0h with no expected entry",
                             k, out_data[k]);
                end else begin
                    mon_e = sbq[k].pop_front();
                    chk($sformatf("out_data%0d", k), 32'(out_data[k]), 32'(mon_e.data));
                    chk($sformatf("out_sat%0d", k), 32'(out_sat[k]), 32'(mon_e.sat));
                end
            end
        end
    end

    initial begin
        int n;
        for (int k = 0; k < N; k++) begin
            in_a[k] = '0;
            in_b[k] = '0;
        end
        in_valid  = '0;
        in_last   = '0;
        out_ready = '1;

        // Reset held two cycles with a valid beat presented
        reset = 1'b0;
        drive(0, 7, 7, 7, 7, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("rst_out_data", 32'(out_data[0]), 32'd0);
        chk("rst_out_sat", 32'(out_sat[0]), 32'd0);
        chk("rst_in_ready", 32'(in_ready[0]), 32'd0);
        reset       = 1'b1;
        in_valid[0] = 1'b0;
        in_last[0]  = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready[0]), 32'd1);
        @(posedge clk);
        #1;

        // Single beat: 3*4=12, -5*6=-30, output exactly two edges later
        drive(0, 3, 4, -5, 6, 1'b1);
        push(0, 16'hE20C, 2'b00);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        in_last[0]  = 1'b0;
        @(negedge clk);
        chk("lat_edge1", 32'(out_valid[0]), 32'd0);
        @(negedge clk);
        chk("lat_edge2", 32'(out_valid[0]), 32'd1);
        @(posedge clk);
        #1;

        // Output saturation: 3*16129 -> 127, 3*-16256 -> -128
        send(0, 127, 127, -128, 127, 1'b0);
        send(0, 127, 127, -128, 127, 1'b0);
        send(0, 127, 127, -128, 127, 1'b1);
        push(0, 16'h807F, 2'b11);
        idle(3);

        // Backpressure: results 1, 4 held back, third beat (9) must wait
        out_ready[0] = 1'b0;
        drive(0, 1, 1, 0, 0, 1'b1);
        push(0, 16'h0001, 2'b00);
        @(posedge clk);
        #1;
        drive(0, 2, 2, 0, 0, 1'b1);
        push(0, 16'h0004, 2'b00);
        @(posedge clk);
        #1;
        drive(0, 3, 3, 0, 0, 1'b1);
        push(0, 16'h0009, 2'b00);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
            chk("bp_out_valid", 32'(out_valid[0]), 32'd1);
            chk("bp_hold_data", 32'(out_data[0]), 32'h0001);
            chk("bp_hold_sat", 32'(out_sat[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        in_last[0]  = 1'b0;
        idle(4);

        // Mid-vector reset discards the partial sum 50
        send(0, 5, 5, 5, 5, 1'b0);
        send(0, 5, 5, 5, 5, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        send(0, 1, 1, 0, 0, 1'b1);
        push(0, 16'h0001, 2'b00);
        idle(3);

        // Accumulator clamp at 32767, (32767+128)>>>8 = 128 -> 127
        send(1, 127, 127, 0, 0, 1'b0);
        send(1, 127, 127, 0, 0, 1'b0);
        send(1, 127, 127, 0, 0, 1'b1);
        push(1, 16'h007F, 2'b01);

        // Rounding: (109+8)>>>4 = 7, (-109+8)>>>4 = -7
        send(2, 10, 10, -10, 10, 1'b0);
        send(2, 3, 3, -3, 3, 1'b1);
        push(2, 16'hF907, 2'b00);

        // Drain all scoreboards with a bounded wait
        n = 0;
        while ((sbq[0].size() != 0 || sbq[1].size() != 0 || sbq[2].size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        for (int k = 0; k < N; k++)
            chk($sformatf("drain%0d", k), 32'(sbq[k].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
